// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the sequential chunked adder/subtractor.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Chunk counter width; never narrower than one bit, even for a single chunk.
  function automatic int cnt_bits(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_adder_chunk.sv
// Combinational W-bit ripple-carry adder assembled from single-bit full adders.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c,
  output logic [W-1:0] sum,
  output logic         carry
);
  logic [W:0] cy;

  assign cy[0] = c;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    full_adder u_fa (
      .a  (a[gi]),
      .b  (b[gi]),
      .ci (cy[gi]),
      .s  (sum[gi]),
      .co (cy[gi+1])
    );
  end

  assign carry = cy[W];
endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract: operands are processed CHUNK bits per clock through
// one shared ripple adder, with a handshake on both the request and result side.
module seq_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = cnt_bits(NCH);
  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] a_cur, b_cur, chunk_sum;
  logic             chunk_carry;

  // Select the chunk of the latched operands addressed by the counter.
  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_q == CW'(i)) begin
        a_cur = a_q[i*CHUNK +: CHUNK];
        b_cur = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  adder_chunk #(.W(CHUNK)) u_chunk (
    .a     (a_cur),
    .b     (b_cur),
    .c     (carry_q),
    .sum   (chunk_sum),
    .carry (chunk_carry)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtraction is folded into addition of ~b with an inverted borrow.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        for (int i = 0; i < NCH; i++) begin
          if (cnt_q == CW'(i)) begin
            sum_d[i*CHUNK +: CHUNK] = chunk_sum;
          end
        end
        carry_d = chunk_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NCH - 1)) begin
          cnt_d   = '0;
          cout_d  = chunk_carry;
          ovf_d   = (a_q[MSB] ~^ b_q[MSB]) & (chunk_sum[CHUNK-1] ^ a_q[MSB]);
          zero_d  = (sum_d == '0);
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub at 16/4, 8/8 and 32/4 with hand-computed results.
module tb_seq_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic        iv16 = 1'b0, ir16, sub16 = 1'b0, cin16 = 1'b0, ov16, or16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        co16, of16, z16;

  logic        iv8 = 1'b0, ir8, sub8 = 1'b0, cin8 = 1'b0, ov8, or8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic        co8, of8, z8;

  logic        iv32 = 1'b0, ir32, sub32 = 1'b0, cin32 = 1'b0, ov32, or32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, s32;
  logic        co32, of32, z32;

  seq_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .sub(sub16), .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .ovf(of16), .zero(z16));

  seq_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .sub(sub8), .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .ovf(of8), .zero(z8));

  seq_addsub #(.WIDTH(32), .CHUNK(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .sub(sub32), .cin(cin32), .out_valid(ov32), .out_ready(or32), .sum(s32),
    .cout(co32), .ovf(of32), .zero(z32));

  task automatic run_op16(input string name, input logic [15:0] a_i, input logic [15:0] b_i,
                          input logic sub_i, input logic cin_i, input logic [15:0] e_sum,
                          input logic e_cout, input logic e_ovf, input logic e_zero, input int hold);
    int lat;
    logic [15:0] s_snap;
    logic c_snap, o_snap, z_snap;
    @(negedge clk);
    a16 = a_i; b16 = b_i; sub16 = sub_i; cin16 = cin_i; iv16 = 1'b1;
    n_checks++;
    if (ir16 !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_idle: got %b need 1", name, ir16);
    end
    @(posedge clk); #1;
    // Keep requesting with scrambled operands: must be ignored while busy.
    a16 = ~a_i; b16 = 16'h5A5A; sub16 = ~sub_i; cin16 = ~cin_i;
    n_checks++;
    if (ir16 !== 1'b0) begin
      n_fail++; $display("FAIL %s ready_busy: got %b need 0", name, ir16);
    end
    lat = 0;
    while (ov16 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat != 4) begin
      n_fail++; $display("FAIL %s latency: got %0d need 4", name, lat);
    end
    n_checks++;
    if ({s16, co16, of16, z16} !== {e_sum, e_cout, e_ovf, e_zero}) begin
      n_fail++;
      $display("FAIL %s result: got sum=%h cout=%b ovf=%b zero=%b need sum=%h cout=%b ovf=%b zero=%b",
               name, s16, co16, of16, z16, e_sum, e_cout, e_ovf, e_zero);
    end
    s_snap = s16; c_snap = co16; o_snap = of16; z_snap = z16;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({ov16, ir16, s16, co16, of16, z16} !== {1'b1, 1'b0, s_snap, c_snap, o_snap, z_snap}) begin
        n_fail++;
        $display("FAIL %s hold_cycle%0d: got valid=%b ready=%b sum=%h need valid=1 ready=0 sum=%h",
                 name, k, ov16, ir16, s16, s_snap);
      end
    end
    iv16 = 1'b0; or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    n_checks++;
    if ({ov16, ir16} !== 2'b01) begin
      n_fail++; $display("FAIL %s release: got valid=%b ready=%b need valid=0 ready=1", name, ov16, ir16);
    end
  endtask

  task automatic run_op8(input string name, input logic [7:0] a_i, input logic [7:0] b_i,
                         input logic [7:0] e_sum, input logic e_cout, input logic e_zero);
    int lat;
    @(negedge clk);
    a8 = a_i; b8 = b_i; sub8 = 1'b0; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'hA5;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat != 1) begin
      n_fail++; $display("FAIL %s latency: got %0d need 1", name, lat);
    end
    n_checks++;
    if ({s8, co8, z8} !== {e_sum, e_cout, e_zero}) begin
      n_fail++;
      $display("FAIL %s result: got sum=%h cout=%b zero=%b need sum=%h cout=%b zero=%b",
               name, s8, co8, z8, e_sum, e_cout, e_zero);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic run_op32(input string name, input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic [31:0] e_sum, input logic e_cout, input logic e_zero);
    int lat;
    @(negedge clk);
    a32 = a_i; b32 = b_i; sub32 = 1'b0; cin32 = 1'b0; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; b32 = 32'hDEADBEEF;
    lat = 0;
    while (ov32 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat != 8) begin
      n_fail++; $display("FAIL %s latency: got %0d need 8", name, lat);
    end
    n_checks++;
    if ({s32, co32, z32} !== {e_sum, e_cout, e_zero}) begin
      n_fail++;
      $display("FAIL %s result: got sum=%h cout=%b zero=%b need sum=%h cout=%b zero=%b",
               name, s32, co32, z32, e_sum, e_cout, e_zero);
    end
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({ir16, ov16, s16, co16, of16, z16} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b valid=%b sum=%h cout=%b ovf=%b zero=%b need 1 0 0000 0 0 0",
               ir16, ov16, s16, co16, of16, z16);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    run_op16("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 0);
    run_op16("add_wrap_zero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    run_op16("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
    run_op16("add_cin", 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_sub();
    run_op16("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);
    run_op16("sub_borrow_hold", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0, 3);
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; cin16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ir16, ov16, s16, co16, of16, z16} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_midrun: got ready=%b valid=%b sum=%h cout=%b ovf=%b zero=%b need 1 0 0000 0 0 0",
               ir16, ov16, s16, co16, of16, z16);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_op16("after_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_widths();
    run_op8("w8_add", 8'h34, 8'h21, 8'h55, 1'b0, 1'b0);
    run_op8("w8_wrap", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    run_op32("w32_add", 32'h0000_1234, 32'h0000_4321, 32'h0000_5555, 1'b0, 1'b0);
    run_op32("w32_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
    run_op32("w32_ripple", 32'h0FFF_FFFF, 32'h0000_0001, 32'h1000_0000, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_reset_midrun();
    test_widths();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
